// File: rtl/datapath_mc.sv
// Multicycle datapath: register file, integer ALU with compare flags, memory bus,
// result mux, and an iterative shift-add multiplier with a Busy/Done handshake.
`timescale 1ns/1ps
module datapath_mc #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [$clog2(NREGS)-1:0]   RS1,
    input  logic [$clog2(NREGS)-1:0]   RS2,
    input  logic [$clog2(NREGS)-1:0]   RD,
    input  logic signed [NBITS-1:0]    IMM,
    input  logic [WIDTH_ALUF-1:0]      ALUControl,
    input  logic                       ALUSrc,
    input  logic                       MemtoReg,
    input  logic                       RegWrite,
    input  logic                       link,
    input  logic [NBITS-1:0]           pclink,
    input  logic                       Start,
    output logic                       Busy,
    output logic                       Done,
    output logic                       Zero,
    output logic                       Neg,
    output logic                       Carry,
    output logic [NBITS-1:0]           PCReg,
    output logic [NBITS-1:2]           Address,
    output logic [NBITS-1:0]           WriteData,
    input  logic [NBITS-1:0]           ReadData
);
    localparam int RBITS = $clog2(NREGS);
    localparam int SBITS = $clog2(NBITS);
    localparam int CBITS = $clog2(NBITS + 1);

    localparam logic [WIDTH_ALUF-1:0] OP_ADD  = WIDTH_ALUF'(0);
    localparam logic [WIDTH_ALUF-1:0] OP_SUB  = WIDTH_ALUF'(1);
    localparam logic [WIDTH_ALUF-1:0] OP_AND  = WIDTH_ALUF'(2);
    localparam logic [WIDTH_ALUF-1:0] OP_OR   = WIDTH_ALUF'(3);
    localparam logic [WIDTH_ALUF-1:0] OP_XOR  = WIDTH_ALUF'(4);
    localparam logic [WIDTH_ALUF-1:0] OP_SLT  = WIDTH_ALUF'(5);
    localparam logic [WIDTH_ALUF-1:0] OP_SLTU = WIDTH_ALUF'(6);
    localparam logic [WIDTH_ALUF-1:0] OP_SLL  = WIDTH_ALUF'(7);
    localparam logic [WIDTH_ALUF-1:0] OP_SRL  = WIDTH_ALUF'(8);
    localparam logic [WIDTH_ALUF-1:0] OP_SRA  = WIDTH_ALUF'(9);
    localparam logic [WIDTH_ALUF-1:0] OP_MUL  = WIDTH_ALUF'(10);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [NBITS-1:0] r_regs [NREGS];
    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [NBITS-1:0] r_mcand;
    logic [NBITS-1:0] r_mplier;
    logic [NBITS-1:0] r_acc;
    logic [CBITS-1:0] r_cnt;
    logic [RBITS-1:0] r_rd;

    logic [NBITS-1:0] w_src_a;
    logic [NBITS-1:0] w_src_b;
    logic [NBITS-1:0] w_rs2_val;
    logic [SBITS-1:0] w_shamt;
    logic [NBITS:0]   w_diff;
    logic             w_neg;
    logic [NBITS-1:0] w_alu_result;
    logic [NBITS-1:0] w_result;
    logic             w_wr_single;

    // x0 is forced to zero on read rather than relying on it never being written.
    assign w_src_a   = (RS1 == '0) ? '0 : r_regs[RS1];
    assign w_rs2_val = (RS2 == '0) ? '0 : r_regs[RS2];
    assign w_src_b   = ALUSrc ? IMM : w_rs2_val;
    assign w_shamt   = w_src_b[SBITS-1:0];

    assign w_diff = {1'b0, w_src_a} + {1'b0, ~w_src_b} + (NBITS+1)'(1);
    assign w_neg  = $signed(w_src_a) < $signed(w_src_b);
    assign Carry  = w_diff[NBITS];
    assign Zero   = (w_diff[NBITS-1:0] == '0);
    assign Neg    = w_neg;

    always_comb begin
        // NOTE: default first so every path assigns w_alu_result and no latch is inferred.
        w_alu_result = w_src_a + w_src_b;
        case (ALUControl)
            OP_ADD:  w_alu_result = w_src_a + w_src_b;
            OP_SUB:  w_alu_result = w_diff[NBITS-1:0];
            OP_AND:  w_alu_result = w_src_a & w_src_b;
            OP_OR:   w_alu_result = w_src_a | w_src_b;
            OP_XOR:  w_alu_result = w_src_a ^ w_src_b;
            OP_SLT:  w_alu_result = {{(NBITS-1){1'b0}}, w_neg};
            OP_SLTU: w_alu_result = {{(NBITS-1){1'b0}}, ~w_diff[NBITS]};
            OP_SLL:  w_alu_result = w_src_a << w_shamt;
            OP_SRL:  w_alu_result = w_src_a >> w_shamt;
            OP_SRA:  w_alu_result = NBITS'($signed(w_src_a) >>> w_shamt);
            default: ;
        endcase
    end

    assign w_result    = link ? pclink : (MemtoReg ? ReadData : w_alu_result);
    assign w_wr_single = RegWrite && !r_busy && (ALUControl != OP_MUL) && (RD != '0);

    assign Address   = w_alu_result[NBITS-1:2];
    assign WriteData = w_rs2_val;
    assign PCReg     = w_src_a;
    assign Busy      = r_busy;
    assign Done      = r_done;

    // NOTE: non-blocking only, so every branch below sees the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the register file is architecturally cleared by reset, so it is a reset flop array, not a RAM.
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_rd     <= '0;
        end else begin
            if (w_wr_single) r_regs[RD] <= w_result;
            case (r_state)
                S_IDLE: begin
                    if (Start && ALUControl == OP_MUL) begin
                        r_mcand  <= w_src_a;
                        r_mplier <= w_src_b;
                        r_rd     <= RD;
                        r_acc    <= '0;
                        r_cnt    <= CBITS'(NBITS);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CBITS'(1);
                    // Last partial product is added on the cnt==1 cycle.
                    if (r_cnt == CBITS'(1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_rd != '0) r_regs[r_rd] <= r_acc;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_datapath_mc.sv
// Self-checking bench for datapath_mc: random ALU/flag/mux traffic and multiplies
// checked against an arithmetic reference model of the register file.
`timescale 1ns/1ps
module tb_datapath_mc;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7,
                           OP_SRL = 4'd8, OP_SRA = 4'd9, OP_MUL = 4'd10;

    logic              clock = 1'b0;
    logic              reset;
    logic [4:0]        RS1, RS2, RD;
    logic signed [7:0] IMM;
    logic [3:0]        ALUControl;
    logic              ALUSrc, MemtoReg, RegWrite, link, Start;
    logic [7:0]        pclink;
    logic              Busy, Done, Zero, Neg, Carry;
    logic [7:0]        PCReg;
    logic [7:2]        Address;
    logic [7:0]        WriteData, ReadData;

    logic [7:0] model_regs [32];
    int n_cmp = 0;
    int n_err = 0;

    datapath_mc dut (
        .clock(clock), .reset(reset), .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM),
        .ALUControl(ALUControl), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .link(link), .pclink(pclink), .Start(Start), .Busy(Busy), .Done(Done),
        .Zero(Zero), .Neg(Neg), .Carry(Carry), .PCReg(PCReg), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sval(input logic [7:0] v);
        return (int'(v) >= 128) ? int'(v) - 256 : int'(v);
    endfunction

    // Reference ALU from plain integer arithmetic.
    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, p;
        ua = int'(a); ub = int'(b); sa = sval(a); sb = sval(b);
        p = 1 << (ub % 8);
        case (op)
            OP_SUB:  return 8'((ua - ub + 256) % 256);
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return (sa < sb) ? 8'd1 : 8'd0;
            OP_SLTU: return (ua < ub) ? 8'd1 : 8'd0;
            OP_SLL:  return 8'((ua * p) % 256);
            OP_SRL:  return 8'(ua / p);
            OP_SRA:  return 8'((sa >= 0) ? sa / p : -((-sa + p - 1) / p));
            default: return 8'((ua + ub) % 256);
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic alusrc, input logic [7:0] imm,
                            input logic we);
        ALUControl = op; RS1 = rs1; RS2 = rs2; RD = rd; ALUSrc = alusrc; IMM = imm;
        RegWrite = we; link = 1'b0; MemtoReg = 1'b0; Start = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] rd, input logic [7:0] val);
        drive_op(OP_ADD, 5'd0, 5'd0, rd, 1'b1, val, 1'b1);
        step();
        RegWrite = 1'b0;
        if (rd != 5'd0) model_regs[rd] = val;
    endtask

    task automatic rd_reg(input logic [4:0] r, output logic [7:0] v);
        RS1 = r; RegWrite = 1'b0; Start = 1'b0;
        step();
        v = PCReg;
    endtask

    task automatic do_mul(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic alusrc, input logic [7:0] imm, input bit hold_start,
                          input bit poke_x4, output int busy_cycles, output int done_cycle,
                          output int pulses, output bit tmo);
        drive_op(OP_MUL, rs1, rs2, rd, alusrc, imm, 1'b0);
        Start = 1'b1;
        busy_cycles = 0; done_cycle = 0; pulses = 0;
        step();
        if (!hold_start) Start = 1'b0;
        if (poke_x4) begin
            ALUControl = OP_ADD; RS1 = 5'd0; ALUSrc = 1'b1; IMM = 8'h5A; RD = 5'd4; RegWrite = 1'b1;
        end
        while (Busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (Done === 1'b1) begin
                pulses++;
                done_cycle = busy_cycles;
            end
            step();
        end
        tmo = (busy_cycles >= 40);
        Start = 1'b0; RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_op(OP_ADD, 5'd5, 5'd5, 5'd0, 1'b0, 8'h00, 1'b0);
        pclink = 8'h00; ReadData = 8'h00;
        step(); step();
        n_cmp++;
        if ({Busy, Done, PCReg, WriteData, Zero, Carry, Neg} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b pc=%h wd=%h z=%b c=%b n=%b, expected 0 0 00 00 1 1 0",
                     Busy, Done, PCReg, WriteData, Zero, Carry, Neg);
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
    endtask

    task automatic test_add_x0();
        logic [7:0] v;
        drive_op(OP_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 8'd5, 1'b1); step();
        drive_op(OP_ADD, 5'd1, 5'd1, 5'd2, 1'b0, 8'd0, 1'b1); step();
        drive_op(OP_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 8'd7, 1'b1); step();
        model_regs[1] = 8'd5; model_regs[2] = 8'd10;
        rd_reg(5'd1, v); n_cmp++;
        if (v !== 8'd5) begin n_err++; $display("FAIL add_imm x1: got %h expected 05", v); end
        rd_reg(5'd2, v); n_cmp++;
        if (v !== 8'd10) begin n_err++; $display("FAIL add_reg x2: got %h expected 0a", v); end
        rd_reg(5'd0, v); n_cmp++;
        if (v !== 8'd0) begin n_err++; $display("FAIL x0_write: got %h expected 00", v); end
    endtask

    task automatic test_flags();
        logic [7:0] fa [3] = '{8'd5, 8'd7, 8'h80};
        logic [7:0] fb [3] = '{8'd7, 8'd7, 8'h01};
        logic [2:0] fz [3] = '{3'b010, 3'b101, 3'b011};  // {Zero,Neg,Carry}
        for (int k = 0; k < 3; k++) begin
            wr_reg(5'd1, fa[k]);
            wr_reg(5'd2, fb[k]);
            drive_op(OP_SUB, 5'd1, 5'd2, 5'd0, 1'b0, 8'd0, 1'b0);
            #1;
            n_cmp++;
            if ({Zero, Neg, Carry} !== fz[k]) begin
                n_err++;
                $display("FAIL flags_%0d: got ZNC=%b expected %b", k, {Zero, Neg, Carry}, fz[k]);
            end
            step();
        end
    endtask

    task automatic test_shifts();
        logic [7:0] sa  [5] = '{8'h80, 8'h80, 8'h81, 8'h80, 8'h80};
        logic [3:0] sop [5] = '{OP_SRA, OP_SRL, OP_SLL, OP_SLTU, OP_SLT};
        logic [7:0] sex [5] = '{8'hC0, 8'h40, 8'h02, 8'h00, 8'h01};
        logic [7:0] v;
        for (int k = 0; k < 5; k++) begin
            wr_reg(5'd1, sa[k]);
            drive_op(sop[k], 5'd1, 5'd0, 5'd5, 1'b1, 8'h01, 1'b1);
            step();
            model_regs[5] = sex[k];
            rd_reg(5'd5, v);
            n_cmp++;
            if (v !== sex[k]) begin
                n_err++;
                $display("FAIL shift_op%0d: got %h expected %h", sop[k], v, sex[k]);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [4:0] rs1, rs2, rd;
        logic [3:0] op;
        logic [7:0] imm, a, b, exp, v;
        logic       alusrc, we;
        for (int r = 1; r < 32; r++) wr_reg(5'(r), 8'($urandom));
        for (int k = 0; k < 60; k++) begin
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            op = 4'($urandom); if (op == OP_MUL) op = 4'd12;
            alusrc = 1'($urandom); we = 1'($urandom); imm = 8'($urandom);
            drive_op(op, rs1, rs2, rd, alusrc, imm, we);
            #1;
            a = model_regs[rs1];
            b = alusrc ? imm : model_regs[rs2];
            exp = alu_ref(op, a, b);
            n_cmp++;
            if ({Zero, Carry, Neg, Address, WriteData, PCReg} !==
                {a == b, int'(a) >= int'(b), sval(a) < sval(b), exp[7:2], model_regs[rs2], a}) begin
                n_err++;
                $display("FAIL alu_rand_%0d op=%0d a=%h b=%h: got ZCN=%b%b%b addr=%h wd=%h pc=%h expected addr=%h wd=%h pc=%h",
                         k, op, a, b, Zero, Carry, Neg, Address, WriteData, PCReg, exp[7:2], model_regs[rs2], a);
            end
            step();
            if (we && rd != 5'd0) model_regs[rd] = exp;
        end
        RegWrite = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rd_reg(5'(r), v);
            n_cmp++;
            if (v !== model_regs[r]) begin
                n_err++;
                $display("FAIL alu_regfile x%0d: got %h expected %h", r, v, model_regs[r]);
            end
        end
    endtask

    task automatic test_mul();
        int bc, dc, pu;
        bit tmo;
        logic [4:0] rs1, rs2, rd;
        logic [7:0] imm, a, b, exp, v;
        logic alusrc;
        // Start with a non-MUL op must not launch.
        drive_op(OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 8'd0, 1'b0);
        Start = 1'b1; step(); Start = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0) begin n_err++; $display("FAIL start_non_mul: got busy=%b expected 0", Busy); end

        wr_reg(5'd1, 8'd13); wr_reg(5'd2, 8'd11);
        do_mul(5'd1, 5'd2, 5'd3, 1'b0, 8'd0, 1'b1, 1'b0, bc, dc, pu, tmo);
        n_cmp++;
        if (tmo || bc != 9 || dc != 9 || pu != 1) begin
            n_err++;
            $display("FAIL mul_timing: got busy=%0d done_at=%0d pulses=%0d timeout=%0b expected 9 9 1 0", bc, dc, pu, tmo);
        end
        step();
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_err++; $display("FAIL mul_start_in_done: got busy=%b done=%b expected 0 0", Busy, Done);
        end
        model_regs[3] = 8'h8F;
        rd_reg(5'd3, v); n_cmp++;
        if (v !== 8'h8F) begin n_err++; $display("FAIL mul_13x11: got %h expected 8f", v); end

        wr_reg(5'd4, 8'h33); wr_reg(5'd1, 8'd20);
        do_mul(5'd1, 5'd1, 5'd6, 1'b0, 8'd0, 1'b0, 1'b1, bc, dc, pu, tmo);
        model_regs[6] = 8'h90;
        rd_reg(5'd6, v); n_cmp++;
        if (v !== 8'h90 || tmo) begin n_err++; $display("FAIL mul_20x20: got %h expected 90", v); end
        rd_reg(5'd4, v); n_cmp++;
        if (v !== 8'h33) begin n_err++; $display("FAIL regwrite_while_busy x4: got %h expected 33", v); end

        do_mul(5'd1, 5'd2, 5'd0, 1'b0, 8'd0, 1'b0, 1'b0, bc, dc, pu, tmo);
        rd_reg(5'd0, v); n_cmp++;
        if (v !== 8'h00 || tmo || bc != 9) begin n_err++; $display("FAIL mul_rd0: got x0=%h busy=%0d expected 00 9", v, bc); end

        for (int k = 0; k < 6; k++) begin
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom_range(1, 31));
            alusrc = 1'($urandom); imm = 8'($urandom);
            a = model_regs[rs1]; b = alusrc ? imm : model_regs[rs2];
            exp = 8'((int'(a) * int'(b)) % 256);
            do_mul(rs1, rs2, rd, alusrc, imm, 1'b0, 1'b0, bc, dc, pu, tmo);
            model_regs[rd] = exp;
            rd_reg(rd, v); n_cmp++;
            if (v !== exp || tmo || bc != 9 || pu != 1) begin
                n_err++;
                $display("FAIL mul_rand_%0d %h*%h: got %h busy=%0d pulses=%0d expected %h 9 1", k, a, b, v, bc, pu, exp);
            end
        end
    endtask

    task automatic test_mul_reset();
        int pulses = 0;
        logic [7:0] v;
        wr_reg(5'd3, 8'h77); wr_reg(5'd1, 8'd13); wr_reg(5'd2, 8'd11);
        drive_op(OP_MUL, 5'd1, 5'd2, 5'd3, 1'b0, 8'd0, 1'b0);
        Start = 1'b1; step(); Start = 1'b0;
        step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_err++; $display("FAIL mul_reset_state: got busy=%b done=%b expected 0 0", Busy, Done);
        end
        for (int c = 0; c < 12; c++) begin
            if (Done === 1'b1) pulses++;
            step();
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL mul_reset_done: got %0d pulses expected 0", pulses); end
        rd_reg(5'd3, v); n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("FAIL mul_reset_x3: got %h expected 00", v); end
    endtask

    task automatic test_result_mux();
        logic [7:0] v, exp, a, b;
        logic [4:0] rs1, rs2, rd;
        logic [3:0] op;
        logic [7:0] imm;
        logic alusrc;
        drive_op(OP_ADD, 5'd0, 5'd0, 5'd1, 1'b0, 8'd0, 1'b1);
        link = 1'b1; pclink = 8'h44; step();
        drive_op(OP_ADD, 5'd0, 5'd0, 5'd2, 1'b0, 8'd0, 1'b1);
        MemtoReg = 1'b1; ReadData = 8'hA5; step();
        drive_op(OP_ADD, 5'd0, 5'd0, 5'd3, 1'b0, 8'd0, 1'b1);
        link = 1'b1; MemtoReg = 1'b1; pclink = 8'h3C; ReadData = 8'h99; step();
        link = 1'b0; MemtoReg = 1'b0;
        model_regs[1] = 8'h44; model_regs[2] = 8'hA5; model_regs[3] = 8'h3C;
        rd_reg(5'd1, v); n_cmp++;
        if (v !== 8'h44) begin n_err++; $display("FAIL link_x1: got %h expected 44", v); end
        rd_reg(5'd2, v); n_cmp++;
        if (v !== 8'hA5) begin n_err++; $display("FAIL load_x2: got %h expected a5", v); end
        rd_reg(5'd3, v); n_cmp++;
        if (v !== 8'h3C) begin n_err++; $display("FAIL link_priority_x3: got %h expected 3c", v); end

        for (int k = 0; k < 16; k++) begin
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            op = 4'($urandom_range(0, 9)); alusrc = 1'($urandom); imm = 8'($urandom);
            drive_op(op, rs1, rs2, rd, alusrc, imm, 1'b1);
            link = 1'($urandom); MemtoReg = 1'($urandom);
            pclink = 8'($urandom); ReadData = 8'($urandom);
            a = model_regs[rs1]; b = alusrc ? imm : model_regs[rs2];
            exp = link ? pclink : (MemtoReg ? ReadData : alu_ref(op, a, b));
            step();
            if (rd != 5'd0) model_regs[rd] = exp;
        end
        link = 1'b0; MemtoReg = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rd_reg(5'(r), v);
            n_cmp++;
            if (v !== model_regs[r]) begin
                n_err++;
                $display("FAIL mux_regfile x%0d: got %h expected %h", r, v, model_regs[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_x0();
        test_flags();
        test_shifts();
        test_alu_random();
        test_mul();
        test_mul_reset();
        test_result_mux();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
